object_spawn_sequencer: RTL and testbench

- Upstream feeder for the multi-object trigger runtime.
- Walks a spawn-pattern ROM one entry at a time and waits the entry's delay, counted in centisecond ticks.
- Presents the entry's object parameters and completes the sync_object_position / update_object_position handshake so the runtime claims a free object slot.
- Runs in the calculation clock domain. The centisecond time base arrives as a one-cycle enable pulse.

---
 rtl/object_spawn_sequencer.sv | 177 +++++++++++++++++
 tb/tb_object_spawn_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/object_spawn_sequencer.sv
// Spawn-pattern sequencer: walks a pattern ROM, waits each entry's centisecond delay and
// hands the entry's object parameters to the trigger runtime via the sync/update handshake.
module object_spawn_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LOOP        = 0,
    parameter int unsigned ACK_TIMEOUT = 1023
) (
    input  logic              clk_calculation,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              centi_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [66:0]       rom_data,
    input  logic              update_object_position,
    output logic              sync_object_position,
    output logic [2:0]        object_movement_direction,
    output logic [9:0]        object_pos_x,
    output logic [9:0]        object_pos_y,
    output logic [9:0]        object_w,
    output logic [9:0]        object_h,
    output logic [4:0]        object_speed,
    output logic [7:0]        object_destroy_time,
    output logic [1:0]        object_destroy_trigger,
    output logic              busy,
    output logic              done,
    output logic [7:0]        spawn_count,
    output logic [7:0]        drop_count
);

    localparam int unsigned ToW = $clog2(ACK_TIMEOUT + 1);
    // sync stays low for the PRESENT cycle plus ACK_TIMEOUT-1 WAIT_ACK cycles
    localparam logic [ToW-1:0] ToLast = ToW'(ACK_TIMEOUT >= 2 ? ACK_TIMEOUT - 2 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StWaitDelay,
        StPresent,
        StWaitAck,
        StRelease,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sync_q, sync_d;
    logic [57:0]       fields_q, fields_d;
    logic [7:0]        delay_q, delay_d;
    logic [ToW-1:0]    to_q, to_d;
    logic [7:0]        spawn_q, spawn_d;
    logic [7:0]        drop_q, drop_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sync_d   = sync_q;
        fields_d = fields_q;
        delay_d  = delay_q;
        to_d     = to_q;
        spawn_d  = spawn_q;
        drop_d   = drop_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    spawn_d = '0;
                    drop_d  = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                if (rom_data[66]) begin
                    if (LOOP != 0) begin
                        addr_d  = '0;
                        state_d = StFetch;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    fields_d = rom_data[57:0];
                    delay_d  = rom_data[65:58];
                    if (rom_data[65:58] == 8'd0) begin
                        state_d = StPresent;
                        sync_d  = 1'b0;
                    end else begin
                        state_d = StWaitDelay;
                    end
                end
            end
            StWaitDelay: begin
                // ticks during pause are dropped, not queued
                if (centi_tick && !pause) begin
                    delay_d = delay_q - 8'd1;
                    if (delay_q == 8'd1) begin
                        state_d = StPresent;
                        sync_d  = 1'b0;
                    end
                end
            end
            StPresent: begin
                sync_d  = 1'b0;
                to_d    = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (update_object_position) begin
                    sync_d  = 1'b1;
                    spawn_d = (spawn_q == 8'hff) ? spawn_q : spawn_q + 8'd1;
                    state_d = StRelease;
                end else if (to_q == ToLast) begin
                    sync_d  = 1'b1;
                    drop_d  = (drop_q == 8'hff) ? drop_q : drop_q + 8'd1;
                    state_d = StRelease;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            StRelease: begin
                if (!update_object_position) begin
                    if (addr_q == '1) begin
                        if (LOOP != 0) begin
                            addr_d  = '0;
                            state_d = StFetch;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_calculation) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            sync_q   <= 1'b1;
            fields_q <= '0;
            delay_q  <= '0;
            to_q     <= '0;
            spawn_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sync_q   <= sync_d;
            fields_q <= fields_d;
            delay_q  <= delay_d;
            to_q     <= to_d;
            spawn_q  <= spawn_d;
            drop_q   <= drop_d;
        end
    end

    assign rom_addr                  = addr_q;
    assign sync_object_position      = sync_q;
    assign object_movement_direction = fields_q[57:55];
    assign object_pos_x              = fields_q[54:45];
    assign object_pos_y              = fields_q[44:35];
    assign object_w                  = fields_q[34:25];
    assign object_h                  = fields_q[24:15];
    assign object_speed              = fields_q[14:10];
    assign object_destroy_time       = fields_q[9:2];
    assign object_destroy_trigger    = fields_q[1:0];
    assign busy                      = (state_q != StIdle) && (state_q != StDone);
    assign done                      = (state_q == StDone);
    assign spawn_count               = spawn_q;
    assign drop_count                = drop_q;

endmodule

// File: tb/tb_object_spawn_sequencer.sv
// Bench for object_spawn_sequencer: directed timing scenarios plus randomized patterns
// checked against a ROM-walk model of the expected presentations and counter totals.
module tb_object_spawn_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start_a, start_b, pause, centi_tick, ack_a, ack_b;
    logic [3:0]  addr_a;
    logic [1:0]  addr_b;
    logic [66:0] data_a, data_b;
    logic [66:0] rom_a [16];
    logic [66:0] rom_b [4];

    logic        sync_a, busy_a, done_a, sync_b, busy_b, done_b;
    logic [2:0]  dir_a, dir_b;
    logic [9:0]  px_a, py_a, w_a, h_a, px_b, py_b, w_b, h_b;
    logic [4:0]  sp_a, sp_b;
    logic [7:0]  dt_a, dt_b, spawn_a, drop_a, spawn_b, drop_b;
    logic [1:0]  tr_a, tr_b;
    logic [57:0] fields_a, fields_b;

    assign fields_a = {dir_a, px_a, py_a, w_a, h_a, sp_a, dt_a, tr_a};
    assign fields_b = {dir_b, px_b, py_b, w_b, h_b, sp_b, dt_b, tr_b};

    // synchronous ROMs: data valid one cycle after the address
    always @(posedge clk) begin
        data_a <= rom_a[addr_a];
        data_b <= rom_b[addr_b];
    end

    object_spawn_sequencer #(.ADDR_W(4), .LOOP(0), .ACK_TIMEOUT(16)) dut_a (
        .clk_calculation(clk), .reset(reset), .start(start_a), .pause(pause),
        .centi_tick(centi_tick), .rom_addr(addr_a), .rom_data(data_a),
        .update_object_position(ack_a), .sync_object_position(sync_a),
        .object_movement_direction(dir_a), .object_pos_x(px_a), .object_pos_y(py_a),
        .object_w(w_a), .object_h(h_a), .object_speed(sp_a), .object_destroy_time(dt_a),
        .object_destroy_trigger(tr_a), .busy(busy_a), .done(done_a),
        .spawn_count(spawn_a), .drop_count(drop_a)
    );

    object_spawn_sequencer #(.ADDR_W(2), .LOOP(1), .ACK_TIMEOUT(16)) dut_b (
        .clk_calculation(clk), .reset(reset), .start(start_b), .pause(pause),
        .centi_tick(centi_tick), .rom_addr(addr_b), .rom_data(data_b),
        .update_object_position(ack_b), .sync_object_position(sync_b),
        .object_movement_direction(dir_b), .object_pos_x(px_b), .object_pos_y(py_b),
        .object_w(w_b), .object_h(h_b), .object_speed(sp_b), .object_destroy_time(dt_b),
        .object_destroy_trigger(tr_b), .busy(busy_b), .done(done_b),
        .spawn_count(spawn_b), .drop_count(drop_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    bit auto_tick = 1'b0;

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (auto_tick) centi_tick = (cyc_n % 4 == 0);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance until the selected DUT presents (sync low), bounded.
    task automatic wait_low(input bit sel, input string tag);
        int n = 0;
        while (((sel ? sync_b : sync_a) !== 1'b0) && n < 400) begin
            cyc();
            n++;
        end
        chk(tag, 64'(n < 400), 64'd1);
    endtask

    function automatic logic [66:0] mk(input logic e, input logic [7:0] dly, input logic [2:0] dir,
                                       input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] w, input logic [9:0] h,
                                       input logic [4:0] sp, input logic [7:0] dt,
                                       input logic [1:0] tr);
        return {e, dly, dir, x, y, w, h, sp, dt, tr};
    endfunction

    initial begin
        logic [66:0] ent_a, ent_b, ent_c, ent_d, ent_e, ent_f, ent_end;
        bit early, stable, hold_bad;
        int low, n, endpos, cnt, exp_spawn, exp_drop, lat, hold;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; pause = 1'b0;
        centi_tick = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        ent_end = mk(1'b1, 8'd0, 3'd0, 10'd0, 10'd0, 10'd0, 10'd0, 5'd0, 8'd0, 2'd0);
        for (int i = 0; i < 16; i++) rom_a[i] = ent_end;
        for (int i = 0; i < 4; i++) rom_b[i] = ent_end;
        repeat (3) cyc();
        chk("rst_sync", 64'(sync_a), 64'd1);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_done", 64'(done_a), 64'd0);
        chk("rst_addr", 64'(addr_a), 64'd0);
        chk("rst_fields", 64'(fields_a), 64'd0);
        chk("rst_counts", 64'({spawn_a, drop_a}), 64'd0);
        reset = 1'b0;
        cyc();

        // Latency with a delay-0 entry, ack two cycles after sync falls
        ent_a = mk(1'b0, 8'd0, 3'd1, 10'd100, 10'd50, 10'd20, 10'd20, 5'd3, 8'd10, 2'd1);
        rom_a[0] = ent_a; rom_a[1] = ent_end;
        start_a = 1'b1; cyc(); start_a = 1'b0;
        chk("lat_c1_sync", 64'(sync_a), 64'd1);
        chk("lat_c1_busy", 64'(busy_a), 64'd1);
        cyc();
        chk("lat_c2_sync", 64'(sync_a), 64'd1);
        cyc();
        chk("lat_c3_sync", 64'(sync_a), 64'd0);
        chk("lat_fields", 64'(fields_a), 64'(ent_a[57:0]));
        cyc(); cyc();
        ack_a = 1'b1; cyc(); ack_a = 1'b0;
        chk("lat_ack_sync", 64'(sync_a), 64'd1);
        chk("lat_spawn", 64'(spawn_a), 64'd1);
        repeat (4) cyc();
        chk("lat_done", 64'({done_a, busy_a, sync_a}), 64'b101);
        chk("lat_counts", 64'({spawn_a, drop_a}), 64'h0100);

        // Delay 5 with a paused 3rd tick, then timeout, long ack hold, ack at expiry
        ent_b = mk(1'b0, 8'd5, 3'd2, 10'd300, 10'd200, 10'd40, 10'd30, 5'd7, 8'd50, 2'd2);
        ent_c = mk(1'b0, 8'd0, 3'd4, 10'd11, 10'd22, 10'd33, 10'd44, 5'd5, 8'd6, 2'd3);
        ent_d = mk(1'b0, 8'd0, 3'd7, 10'd500, 10'd400, 10'd64, 10'd32, 5'd31, 8'd255, 2'd0);
        rom_a[0] = ent_b; rom_a[1] = ent_c; rom_a[2] = ent_d; rom_a[3] = ent_end;
        start_a = 1'b1; cyc(); start_a = 1'b0;
        early = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            repeat (9) begin
                cyc();
                if (sync_a !== 1'b1) early = 1'b1;
            end
            centi_tick = 1'b1; pause = (t == 3);
            cyc();
            centi_tick = 1'b0; pause = 1'b0;
            if (t < 6 && sync_a !== 1'b1) early = 1'b1;
        end
        chk("pause_no_early_fall", 64'(early), 64'd0);
        chk("pause_fall_after_6th", 64'(sync_a), 64'd0);
        chk("delay_fields", 64'(fields_a), 64'(ent_b[57:0]));
        low = 0; stable = 1'b1;
        while (sync_a === 1'b0 && low < 100) begin
            low++;
            if (fields_a !== ent_b[57:0]) stable = 1'b0;
            cyc();
        end
        chk("timeout_low_cycles", 64'(low), 64'd16);
        chk("timeout_fields_stable", 64'(stable), 64'd1);
        chk("timeout_counts", 64'({spawn_a, drop_a}), 64'h0001);

        wait_low(1'b0, "next_entry_present");
        chk("next_entry_fields", 64'(fields_a), 64'(ent_c[57:0]));
        cyc();
        ack_a = 1'b1; hold_bad = 1'b0;
        repeat (4) begin
            cyc();
            if (sync_a !== 1'b1 || busy_a !== 1'b1) hold_bad = 1'b1;
        end
        ack_a = 1'b0;
        chk("hold_stays_release", 64'(hold_bad), 64'd0);
        n = 0;
        while (sync_a !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        chk("hold_present_after_drop", 64'(n), 64'd3);
        chk("hold_fields", 64'(fields_a), 64'(ent_d[57:0]));
        chk("hold_spawn", 64'(spawn_a), 64'd1);
        repeat (15) cyc();
        chk("expiry_still_low", 64'(sync_a), 64'd0);
        ack_a = 1'b1; cyc(); ack_a = 1'b0;
        chk("expiry_ack_sync", 64'(sync_a), 64'd1);
        chk("expiry_ack_counts", 64'({spawn_a, drop_a}), 64'h0201);
        repeat (4) cyc();
        chk("expiry_done", 64'(done_a), 64'd1);

        // LOOP=1: wrap on end flag and replay the first entry
        ent_e = mk(1'b0, 8'd0, 3'd1, 10'd1, 10'd2, 10'd3, 10'd4, 5'd5, 8'd6, 2'd1);
        ent_f = mk(1'b0, 8'd0, 3'd6, 10'd900, 10'd800, 10'd700, 10'd600, 5'd17, 8'd99, 2'd2);
        rom_b[0] = ent_e; rom_b[1] = ent_f; rom_b[2] = ent_end;
        start_b = 1'b1; cyc(); start_b = 1'b0;
        wait_low(1'b1, "loop_p1");
        chk("loop_p1_fields", 64'(fields_b), 64'(ent_e[57:0]));
        cyc(); ack_b = 1'b1; cyc(); ack_b = 1'b0;
        wait_low(1'b1, "loop_p2");
        chk("loop_p2_fields", 64'(fields_b), 64'(ent_f[57:0]));
        cyc(); ack_b = 1'b1; cyc(); ack_b = 1'b0;
        wait_low(1'b1, "loop_p3");
        chk("loop_p3_fields", 64'(fields_b), 64'(ent_e[57:0]));
        chk("loop_p3_addr", 64'(addr_b), 64'd0);
        chk("loop_not_done", 64'(done_b), 64'd0);
        chk("loop_spawn", 64'(spawn_b), 64'd2);

        // Reset while waiting for ack, then replay from address 0
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst_mid_sync_busy", 64'({sync_b, busy_b}), 64'b10);
        chk("rst_mid_counts", 64'({spawn_b, drop_b}), 64'd0);
        chk("rst_mid_addr", 64'(addr_b), 64'd0);
        start_b = 1'b1; cyc(); start_b = 1'b0;
        wait_low(1'b1, "replay");
        chk("replay_fields", 64'(fields_b), 64'(ent_e[57:0]));
        chk("replay_addr", 64'(addr_b), 64'd0);

        // Randomized patterns against a ROM-walk model
        auto_tick = 1'b1;
        for (int it = 0; it < 4; it++) begin
            endpos = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++)
                rom_a[i] = (i == endpos) ? ent_end
                         : {1'b0, 8'($urandom_range(0, 3)), 58'({$urandom, $urandom})};
            cnt = endpos;
            exp_spawn = 0; exp_drop = 0;
            start_a = 1'b1; cyc(); start_a = 1'b0;
            for (int k = 0; k < cnt; k++) begin
                wait_low(1'b0, $sformatf("rnd%0d_present%0d", it, k));
                chk($sformatf("rnd%0d_fields%0d", it, k), 64'(fields_a), 64'(rom_a[k][57:0]));
                if ($urandom_range(0, 3) == 0) begin
                    n = 0;
                    while (sync_a === 1'b0 && n < 100) begin
                        cyc();
                        n++;
                    end
                    exp_drop++;
                end else begin
                    lat = $urandom_range(1, 4);
                    hold = $urandom_range(1, 3);
                    repeat (lat) cyc();
                    ack_a = 1'b1;
                    repeat (hold) cyc();
                    ack_a = 1'b0;
                    exp_spawn++;
                end
            end
            repeat (6) cyc();
            chk($sformatf("rnd%0d_done", it), 64'(done_a), 64'd1);
            chk($sformatf("rnd%0d_spawn", it), 64'(spawn_a), 64'(exp_spawn));
            chk($sformatf("rnd%0d_drop", it), 64'(drop_a), 64'(exp_drop));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
